// File: rtl/pio_edgecap_ctrl_if.sv
// Avalon-MM slave bus bundle for the edge-capture PIO: address, select,
// write strobe and 32-bit write/read data.
interface pio_edgecap_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_edgecap_ctrl.sv
// Avalon-MM GPIO slave: output register, synchronised input with per-bit edge
// capture and maskable level irq. Define PIO_SETCLR_EN to add OUTSET/OUTCLR.
module pio_edgecap_ctrl #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned OUT_RESET_VALUE = 0,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pio_edgecap_ctrl_if.slave     bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam int unsigned DW      = DATA_WIDTH;
    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_OUT     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef PIO_SETCLR_EN
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

    logic [DW-1:0]    sync_q [SYNC_STAGES];
    logic [DW-1:0]    in_sync;
    logic [DW-1:0]    prev_q;
    logic [DW-1:0]    out_reg;
    logic [DW-1:0]    irqmask;
    logic [DW-1:0]    edgecap;
    logic [ARM_W-1:0] arm_cnt;

    logic             wr_c;
    logic             armed_c;
    logic [DW-1:0]    wd_c;
    logic [DW-1:0]    edge_det_c;
    logic [DW-1:0]    clr_c;
    logic [DW-1:0]    out_next_c;
    logic [DW-1:0]    irqmask_next_c;
    logic [DW-1:0]    edgecap_next_c;
    logic [31:0]      rd_next_c;
    logic             unused_wd_bits;

    assign in_sync        = sync_q[SYNC_STAGES-1];
    assign wr_c           = bus.chipselect & ~bus.write_n;
    assign wd_c           = bus.writedata[DW-1:0];
    assign armed_c        = (arm_cnt == ARM_W'(ARM_MAX));
    assign out_port       = out_reg;
    assign unused_wd_bits = ^bus.writedata;

    // Input synchroniser, previous-sample register and post-reset arm counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q  <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= in_sync;
            if (!armed_c) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    // Edge flavour is fixed at elaboration
    always_comb begin
        edge_det_c = in_sync & ~prev_q;
        case (EDGE_TYPE)
            1:       edge_det_c = ~in_sync & prev_q;
            2:       edge_det_c = in_sync ^ prev_q;
            default: edge_det_c = in_sync & ~prev_q;
        endcase
    end

    // Register write decode; a fresh edge overrides a same-cycle W1C
    always_comb begin
        out_next_c     = out_reg;
        irqmask_next_c = irqmask;
        clr_c          = '0;
        if (wr_c) begin
            case (bus.address)
                ADDR_DATA,
                ADDR_OUT:     out_next_c     = wd_c;
                ADDR_IRQMASK: irqmask_next_c = wd_c;
                ADDR_EDGECAP: clr_c          = wd_c;
`ifdef PIO_SETCLR_EN
                ADDR_OUTSET:  out_next_c     = out_reg | wd_c;
                ADDR_OUTCLR:  out_next_c     = out_reg & ~wd_c;
`endif
                default: ;
            endcase
        end
        edgecap_next_c = (edgecap & ~clr_c) | (edge_det_c & {DW{armed_c}});
    end

    // Read mux, loaded every cycle for a single-cycle read latency
    always_comb begin
        rd_next_c = '0;
        case (bus.address)
            ADDR_DATA:    rd_next_c = 32'(in_sync);
            ADDR_OUT:     rd_next_c = 32'(out_reg);
            ADDR_IRQMASK: rd_next_c = 32'(irqmask);
            ADDR_EDGECAP: rd_next_c = 32'(edgecap);
            default:      rd_next_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_reg      <= DW'(OUT_RESET_VALUE);
            irqmask      <= '0;
            edgecap      <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            out_reg      <= out_next_c;
            irqmask      <= irqmask_next_c;
            edgecap      <= edgecap_next_c;
            bus.readdata <= rd_next_c;
            irq          <= |(edgecap & irqmask);
        end
    end

endmodule

// File: tb/tb_pio_edgecap_ctrl.sv
// Bench for pio_edgecap_ctrl: rising/falling/any-edge instances share stimulus
// and are checked every cycle against a pin-history reference model.
module tb_pio_edgecap_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [7:0]  out_port [3];
    logic        irq      [3];
    logic [31:0] rdata    [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pio_edgecap_ctrl_if bus0 ();
    pio_edgecap_ctrl_if bus1 ();
    pio_edgecap_ctrl_if bus2 ();

    assign bus0.address = address;   assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;   assign bus0.writedata  = writedata;
    assign bus1.address = address;   assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;   assign bus1.writedata  = writedata;
    assign bus2.address = address;   assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;   assign bus2.writedata  = writedata;
    assign rdata[0] = bus0.readdata;
    assign rdata[1] = bus1.readdata;
    assign rdata[2] = bus2.readdata;

    pio_edgecap_ctrl #(.DATA_WIDTH(8), .OUT_RESET_VALUE(32'hA5), .EDGE_TYPE(0), .SYNC_STAGES(S))
        u_rise (.clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port),
                .out_port(out_port[0]), .irq(irq[0]));
    pio_edgecap_ctrl #(.DATA_WIDTH(8), .OUT_RESET_VALUE(32'hA5), .EDGE_TYPE(1), .SYNC_STAGES(S))
        u_fall (.clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port),
                .out_port(out_port[1]), .irq(irq[1]));
    pio_edgecap_ctrl #(.DATA_WIDTH(8), .OUT_RESET_VALUE(32'hA5), .EDGE_TYPE(2), .SYNC_STAGES(S))
        u_any  (.clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port),
                .out_port(out_port[2]), .irq(irq[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Reference model: pins are remembered per clock edge; edges are derived
    // from the pin samples S and S+1 edges back, once far enough past reset.
    logic [7:0]  hist [64];
    int          cyc      = 0;
    int          last_rst = -1000;
    bit          m_valid  = 1'b0;
    logic [7:0]  m_out  [3];
    logic [7:0]  m_mask [3];
    logic [7:0]  m_ecap [3];
    logic        m_irq  [3];
    logic [31:0] m_rd   [3];

    task automatic model_step();
        int         t;
        logic [7:0] a, b, ins, edg, wd, clr;
        bit         wr, armed;
        t = cyc;
        hist[t & 63] = in_port;
        if (!reset_n) begin
            last_rst = t;
            m_valid  = 1'b1;
            for (int e = 0; e < 3; e++) begin
                m_out[e] = 8'hA5; m_mask[e] = 8'h00; m_ecap[e] = 8'h00;
                m_irq[e] = 1'b0;  m_rd[e]   = 32'h0;
            end
        end else begin
            ins   = (t - S >= last_rst + 1) ? hist[(t - S) & 63] : 8'h00;
            armed = (t >= last_rst + S + 2);
            a     = armed ? hist[(t - S) & 63]     : 8'h00;
            b     = armed ? hist[(t - S - 1) & 63] : 8'h00;
            wr    = chipselect && !write_n;
            wd    = writedata[7:0];
            clr   = (wr && address == 3'd3) ? wd : 8'h00;
            for (int e = 0; e < 3; e++) begin
                if (!armed)      edg = 8'h00;
                else if (e == 0) edg = a & ~b;
                else if (e == 1) edg = ~a & b;
                else             edg = a ^ b;
                case (address)
                    3'd0:    m_rd[e] = {24'h0, ins};
                    3'd1:    m_rd[e] = {24'h0, m_out[e]};
                    3'd2:    m_rd[e] = {24'h0, m_mask[e]};
                    3'd3:    m_rd[e] = {24'h0, m_ecap[e]};
                    default: m_rd[e] = 32'h0;
                endcase
                m_irq[e]  = |(m_ecap[e] & m_mask[e]);
                m_ecap[e] = (m_ecap[e] & ~clr) | edg;
                if (wr) begin
                    if (address == 3'd0 || address == 3'd1) m_out[e] = wd;
                    if (address == 3'd2) m_mask[e] = wd;
`ifdef PIO_SETCLR_EN
                    if (address == 3'd4) m_out[e] = m_out[e] | wd;
                    if (address == 3'd5) m_out[e] = m_out[e] & ~wd;
`endif
                end
            end
        end
        cyc++;
    endtask

    always @(posedge clk) model_step();

    // Cycle-by-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (m_valid) begin
            for (int e = 0; e < 3; e++) begin
                chk($sformatf("out_port[%0d]", e), 32'(out_port[e]), 32'(m_out[e]));
                chk($sformatf("readdata[%0d]", e), rdata[e], m_rd[e]);
                chk($sformatf("irq[%0d]", e), 32'(irq[e]), 32'(m_irq[e]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        idle_bus();
    endtask

    logic [7:0] exp_set, exp_clr;

    initial begin
`ifdef PIO_SETCLR_EN
        exp_set = 8'hBD; exp_clr = 8'hB1;
`else
        exp_set = 8'h3C; exp_clr = 8'h3C;
`endif
        reset_n = 1'b0; in_port = 8'hFF; address = 3'd6;
        idle_bus();
        repeat (3) tick();
        chk("reset out_port", 32'(out_port[0]), 32'hA5);
        chk("reset irq", 32'(irq[0]), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("readdata after release", rdata[0], 32'h0);

        // Pins high through reset release must not register as edges
        repeat (10) tick();
        address = 3'd3;
        tick();
        chk("no spurious rise", rdata[0], 32'h0);
        chk("no spurious any", rdata[2], 32'h0);
        chk("no spurious irq", 32'(irq[2]), 32'h0);

        bus_write(3'd1, 32'h3C);
        chk("out write", 32'(out_port[0]), 32'h3C);
        bus_write(3'd4, 32'h81);
        chk("outset", 32'(out_port[0]), 32'(exp_set));
        bus_write(3'd5, 32'h0C);
        chk("outclr", 32'(out_port[0]), 32'(exp_clr));
        address = 3'd1;
        tick();
        chk("read out", rdata[0], 32'(exp_clr));

        // Rising edge on bit0: capture at k+2, irq at k+3, W1C drops irq two edges later
        bus_write(3'd2, 32'h01);
        in_port = 8'hFE;
        repeat (6) tick();
        bus_write(3'd3, 32'hFF);
        address = 3'd3;
        in_port = 8'hFF;
        tick();                                         // k
        tick();                                         // k+1
        tick();                                         // k+2
        chk("irq before k+3", 32'(irq[0]), 32'h0);
        chk("edgecap before k+2", rdata[0], 32'h0);
        tick();                                         // k+3
        chk("irq at k+3", 32'(irq[0]), 32'h1);
        chk("edgecap at k+2", rdata[0], 32'h01);
        bus_write(3'd3, 32'h01);
        chk("irq one edge after w1c", 32'(irq[0]), 32'h1);
        tick();
        chk("irq two edges after w1c", 32'(irq[0]), 32'h0);
        chk("edgecap cleared", rdata[0], 32'h0);

        // W1C on the same edge a new edge is captured: the edge wins
        in_port = 8'hFE;
        repeat (6) tick();
        in_port = 8'hFF;
        tick();                                         // k
        tick();                                         // k+1
        address = 3'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h01;
        tick();                                         // k+2
        idle_bus();
        chk("any irq held at k+2", 32'(irq[2]), 32'h1);
        tick();                                         // k+3
        chk("edge beats w1c rise", rdata[0], 32'h01);
        chk("edge beats w1c any", rdata[2], 32'h01);
        chk("irq after race rise", 32'(irq[0]), 32'h1);
        chk("irq after race any", 32'(irq[2]), 32'h1);

        // Any-edge capture of bit3 high then low
        in_port = 8'hF7;
        repeat (5) tick();
        bus_write(3'd3, 32'hFF);
        address = 3'd3;
        in_port = 8'hFF;
        repeat (10) tick();
        chk("any rise bit3", rdata[2], 32'h08);
        chk("rise bit3", rdata[0], 32'h08);
        chk("fall ignores rise", rdata[1], 32'h00);
        bus_write(3'd3, 32'h08);
        tick();
        chk("bit3 cleared", rdata[2], 32'h00);
        in_port = 8'hF7;
        repeat (10) tick();
        chk("any fall bit3", rdata[2], 32'h08);
        chk("fall bit3", rdata[1], 32'h08);
        chk("rise ignores fall", rdata[0], 32'h00);

        // Randomised traffic with sparse pin toggles and occasional resets
        for (int n = 0; n < 3000; n++) begin
            reset_n    = ($urandom_range(0, 199) != 0);
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0)
                in_port = in_port ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            tick();
        end
        reset_n = 1'b1;
        idle_bus();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
